// File: rtl/dmem_resp_pkg.sv
// dmem_responder shared types: FSM state encoding and wait-counter width.
// Imported by dmem_responder; no ports.
package dmem_resp_pkg;

  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_resp_array.sv
// Word storage for dmem_responder: byte-strobed sync write, registered read.
// Ports: clk, we/wstrb/wdata write, re read, addr word index, rdata.
module dmem_resp_array #(
  parameter int DEPTH = 256,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic          re,
  input  logic [3:0]    wstrb,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we && wstrb[b]) begin
        r_mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
    if (re) begin
      r_rdata <= r_mem[addr];
    end
  end

  assign rdata = r_rdata;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready request in, wait states, held response.
// Ports: clk, reset, req_* (valid/ready/write/addr/wdata/wstrb),
// resp_* (valid/ready/rdata/err). Option macro: DMEM_RESP_ALIGN_CHECK_EN.
module dmem_responder
  import dmem_resp_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_wstrb,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH_WORDS);
  localparam logic [CNT_W-1:0] C_LAST =
    CNT_W'((WAIT_CYCLES == 0) ? 0 : WAIT_CYCLES - 1);

  state_t           r_state;
  state_t           w_state_nx;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nx;
  logic             w_fire;
  logic             w_accept;

  logic             r_write;
  logic [31:0]      r_addr;
  logic [31:0]      r_wdata;
  logic [3:0]       r_wstrb;

  logic             w_a_write;
  logic [31:0]      w_a_addr;
  logic [31:0]      w_a_wdata;
  logic [3:0]       w_a_wstrb;
  logic             w_err;

  logic             r_err;
  logic             r_rd_ok;
  logic [31:0]      w_arr_rdata;

  assign w_accept = req_valid && (r_state == ST_IDLE);

  // With zero wait states the access fires on the accept edge,
  // so it must see the live request rather than the latched copy.
  assign w_a_write = (r_state == ST_IDLE) ? req_write : r_write;
  assign w_a_addr  = (r_state == ST_IDLE) ? req_addr  : r_addr;
  assign w_a_wdata = (r_state == ST_IDLE) ? req_wdata : r_wdata;
  assign w_a_wstrb = (r_state == ST_IDLE) ? req_wstrb : r_wstrb;

`ifdef DMEM_RESP_ALIGN_CHECK_EN
  assign w_err = (|(w_a_addr >> (AW + 2))) || (|w_a_addr[1:0]);
`else
  logic w_unused_lsb;
  assign w_unused_lsb = ^w_a_addr[1:0];
  assign w_err = |(w_a_addr >> (AW + 2));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_fire     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (req_valid) begin
          w_cnt_nx = '0;
          if (WAIT_CYCLES == 0) begin
            w_state_nx = ST_RESP;
            w_fire     = 1'b1;
          end else begin
            w_state_nx = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == C_LAST) begin
          w_state_nx = ST_RESP;
          w_cnt_nx   = '0;
          w_fire     = 1'b1;
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          w_state_nx = ST_IDLE;
        end
      end
      default: w_state_nx = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready  = (r_state == ST_IDLE);
    resp_valid = (r_state == ST_RESP);
    resp_err   = r_err;
    resp_rdata = r_rd_ok ? w_arr_rdata : 32'h0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_write <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_wstrb <= '0;
      r_err   <= 1'b0;
      r_rd_ok <= 1'b0;
    end else begin
      if (w_accept) begin
        r_write <= req_write;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_wstrb <= req_wstrb;
      end
      if (w_fire) begin
        r_err   <= w_err;
        r_rd_ok <= !w_a_write && !w_err;
      end
    end
  end

  dmem_resp_array #(
    .DEPTH (DEPTH_WORDS),
    .AW    (AW)
  ) u_array (
    .clk   (clk),
    .we    (w_fire && w_a_write && !w_err),
    .re    (w_fire && !w_a_write && !w_err),
    .wstrb (w_a_wstrb),
    .addr  (w_a_addr[AW+1:2]),
    .wdata (w_a_wdata),
    .rdata (w_arr_rdata)
  );

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder (DEPTH_WORDS=256, WAIT_CYCLES=2).
// Honours DMEM_RESP_ALIGN_CHECK_EN for the misaligned-load expectation.
module tb_dmem_responder;

  logic        clk;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_wstrb;
  logic        resp_valid;
  logic        resp_ready;
  logic [31:0] resp_rdata;
  logic        resp_err;

  int n_cmp;
  int n_bad;

  dmem_responder #(
    .DEPTH_WORDS (256),
    .WAIT_CYCLES (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_write  (req_write),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .req_wstrb  (req_wstrb),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  // One transaction. Latency counts edges from the accept edge
  // (inclusive) through the edge that raises resp_valid.
  // resp_ready is held low for 'stall' cycles while checking hold.
  task automatic xfer(input logic        w,
                      input logic [31:0] a,
                      input logic [31:0] d,
                      input logic [3:0]  s,
                      input int          stall,
                      output logic [31:0] rd,
                      output logic        e,
                      output int          lat);
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_addr   = a;
    req_wdata  = d;
    req_wstrb  = s;
    resp_ready = 1'b0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 1;
    while (!resp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    rd = resp_rdata;
    e  = resp_err;
    for (int i = 0; i < stall; i++) begin
      req_valid = 1'b1;
      req_write = 1'b1;
      req_addr  = 32'h10;
      req_wdata = 32'h55555555;
      req_wstrb = 4'hF;
      @(posedge clk); #1;
      chk("stall_valid", {31'd0, resp_valid}, 32'd1);
      chk("stall_rdata", resp_rdata, rd);
      chk("stall_ready", {31'd0, req_ready}, 32'd0);
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("ret_idle_valid", {31'd0, resp_valid}, 32'd0);
    chk("ret_idle_ready", {31'd0, req_ready}, 32'd1);
  endtask

  logic [31:0] rd;
  logic        e;
  int          lat;

  initial begin
    n_cmp      = 0;
    n_bad      = 0;
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_write  = 1'b0;
    req_addr   = '0;
    req_wdata  = '0;
    req_wstrb  = '0;
    resp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_valid", {31'd0, resp_valid}, 32'd0);
    chk("rst_rdata", resp_rdata, 32'h0);
    chk("rst_err", {31'd0, resp_err}, 32'd0);

    xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, e, lat);
    chk("st_lat", lat, 3);
    chk("st_rdata", rd, 32'h0);
    chk("st_err", {31'd0, e}, 32'd0);

    xfer(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, e, lat);
    chk("ld_lat", lat, 3);
    chk("ld_rdata", rd, 32'hDEADBEEF);
    chk("ld_err", {31'd0, e}, 32'd0);

    xfer(1'b1, 32'h10, 32'h000000AA, 4'h1, 0, rd, e, lat);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, e, lat);
    chk("strb_rdata", rd, 32'hDEADBEAA);

    xfer(1'b1, 32'h10, 32'h12345678, 4'h0, 0, rd, e, lat);
    chk("nostrb_err", {31'd0, e}, 32'd0);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, e, lat);
    chk("nostrb_rdata", rd, 32'hDEADBEAA);

    xfer(1'b1, 32'h0, 32'h11111111, 4'hF, 0, rd, e, lat);
    xfer(1'b0, 32'h400, 32'h0, 4'h0, 0, rd, e, lat);
    chk("oor_ld_err", {31'd0, e}, 32'd1);
    chk("oor_ld_rdata", rd, 32'h0);
    xfer(1'b1, 32'h400, 32'h99999999, 4'hF, 0, rd, e, lat);
    chk("oor_st_err", {31'd0, e}, 32'd1);
    xfer(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, e, lat);
    chk("oor_w0", rd, 32'h11111111);
    chk("oor_w0_err", {31'd0, e}, 32'd0);

    xfer(1'b0, 32'h10, 32'h0, 4'h0, 5, rd, e, lat);
    chk("stall_ld", rd, 32'hDEADBEAA);
    xfer(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, e, lat);
    chk("stall_noacc", rd, 32'hDEADBEAA);

    xfer(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 0, rd, e, lat);
    @(negedge clk);
    req_valid = 1'b1;
    req_write = 1'b1;
    req_addr  = 32'h20;
    req_wdata = 32'h0BADBAD0;
    req_wstrb = 4'hF;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    #2;
    chk("arst_valid", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("arst_ready", {31'd0, req_ready}, 32'd1);
    chk("arst_valid2", {31'd0, resp_valid}, 32'd0);
    repeat (3) @(posedge clk);
    xfer(1'b0, 32'h20, 32'h0, 4'h0, 0, rd, e, lat);
    chk("arst_old", rd, 32'hCAFEF00D);

    xfer(1'b0, 32'h13, 32'h0, 4'h0, 0, rd, e, lat);
`ifdef DMEM_RESP_ALIGN_CHECK_EN
    chk("mis_err", {31'd0, e}, 32'd1);
    chk("mis_rdata", rd, 32'h0);
`else
    chk("mis_err", {31'd0, e}, 32'd0);
    chk("mis_rdata", rd, 32'hDEADBEAA);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
